serial_subtractor: RTL

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

---
 rtl/serial_subtractor.sv | 130 +++++++++++++
 1 files changed

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: one full-subtractor bit per clock, LSB first.
// diff/bout are loaded once at the end of a run and held until the next one.
module serial_subtractor #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             busy,
    output logic             done
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_n;

    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [WIDTH-1:0] sd;
    logic             bw;
    logic [CW-1:0]    cnt;

    logic             ai;
    logic             bi;
    logic             d;
    logic             bw_n;
    logic             last;
    logic             accept;

    // One-bit full subtractor on the current LSBs of the shift registers.
    assign ai   = sa[0];
    assign bi   = sb[0];
    assign d    = ai ^ bi ^ bw;
    assign bw_n = (~ai & bi) | (~(ai ^ bi) & bw);

    // The counter holds the index of the bit being processed this cycle.
    assign last = (cnt == CW'(WIDTH - 1));

    // Next-state logic; a new operation is accepted only from IDLE or DONE.
    always_comb begin
        state_n = state;
        accept  = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    accept  = 1'b1;
                    state_n = RUN;
                end
            end
            RUN: begin
                if (last) begin
                    state_n = DONE;
                end
            end
            DONE: begin
                if (start) begin
                    accept  = 1'b1;
                    state_n = RUN;
                end else begin
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // State register; reset wins over everything, including start.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Status flags are registered copies of the upcoming state.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            busy <= (state_n == RUN);
            done <= (state_n == DONE);
        end
    end

    // Operand capture, bit-serial datapath and result load.
    always_ff @(posedge clk) begin
        if (rst) begin
            sa   <= '0;
            sb   <= '0;
            sd   <= '0;
            bw   <= 1'b0;
            cnt  <= '0;
            diff <= '0;
            bout <= 1'b0;
        end else if (accept) begin
            sa  <= a;
            sb  <= b;
            sd  <= '0;
            bw  <= bin;
            cnt <= '0;
        end else if (state == RUN) begin
            sa  <= sa >> 1;
            sb  <= sb >> 1;
            sd  <= {d, sd[WIDTH-1:1]};
            bw  <= bw_n;
            cnt <= cnt + CW'(1);
            if (last) begin
                diff <= {d, sd[WIDTH-1:1]};
                bout <= bw_n;
            end
        end
    end

endmodule
